// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end feeding the IF/ID register.
// Owns the architectural PC and runs a req/ack handshake to instruction memory.
// It keeps a one-entry instruction buffer and handles branch redirection,
// including discarding a memory response that is already in flight.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   freeze              hazard stall: buffered instruction is held, not consumed
//   Branch_taken        redirect request from EXE
//   Branch_Address      redirect target
//   imem_req/imem_addr  level request and fetch address to instruction memory
//   imem_ack/imem_rdata one-cycle completion pulse with the fetched word
//   PC_out              buffered instruction address + PC_STEP
//   Instruction_out     buffered instruction
//   valid_out           buffer holds a deliverable instruction
//   fetch_stall         ~valid_out, ORed with the hazard freeze for IF/ID load
//   stall_cycles        perf: cycles with fetch_stall=1 (0 unless FETCH_PERF_CNT_EN)
//   discard_count       perf: dropped memory responses (0 unless FETCH_PERF_CNT_EN)
//
// Optional feature macro: FETCH_PERF_CNT_EN enables the saturating perf counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_Address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction_out,
    output logic        valid_out,
    output logic        fetch_stall,
    output logic [31:0] stall_cycles,
    output logic [15:0] discard_count
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STALL_W = 32;
    localparam int unsigned DISC_W  = 16;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        READY   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] buf_inst;
    logic [XLEN-1:0] buf_pc;

    // Fetch FSM with the PC and the one-entry instruction buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            buf_inst <= '0;
            buf_pc   <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (Branch_taken) begin
                        // A response arriving with the redirect is simply dropped;
                        // otherwise the outstanding request must be drained first.
                        pc <= Branch_Address;
                        if (!imem_ack) begin
                            state <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        buf_inst <= imem_rdata;
                        buf_pc   <= pc;
                        state    <= READY;
                    end
                end
                READY: begin
                    // Redirect beats freeze; otherwise an unfrozen cycle consumes the buffer.
                    if (Branch_taken) begin
                        pc    <= Branch_Address;
                        state <= FETCH;
                    end else if (!freeze) begin
                        pc    <= pc + PC_STEP;
                        state <= FETCH;
                    end
                end
                DISCARD: begin
                    if (Branch_taken) begin
                        pc <= Branch_Address;
                    end
                    if (imem_ack) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Output decode from registered state; request is suppressed during reset.
    assign imem_req        = rst && (state == FETCH);
    assign imem_addr       = pc;
    assign valid_out       = (state == READY);
    assign fetch_stall     = (state != READY);
    assign Instruction_out = buf_inst;
    assign PC_out          = buf_pc + PC_STEP;

`ifdef FETCH_PERF_CNT_EN
    logic [STALL_W-1:0] stall_q;
    logic [DISC_W-1:0]  disc_q;
    logic               drop_c;

    // A response is dropped when it lands in DISCARD or alongside a redirect in FETCH.
    assign drop_c = imem_ack && (((state == FETCH) && Branch_taken) || (state == DISCARD));

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            disc_q  <= '0;
        end else begin
            if ((state != READY) && (stall_q != '1)) begin
                stall_q <= stall_q + STALL_W'(1);
            end
            if (drop_c && (disc_q != '1)) begin
                disc_q <= disc_q + DISC_W'(1);
            end
        end
    end

    assign stall_cycles  = stall_q;
    assign discard_count = disc_q;
`else
    assign stall_cycles  = '0;
    assign discard_count = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: self-checking bench for if_fetch_unit.
// Directed reset check, a table of zero-wait vectors (sequential fetch, freeze,
// freeze+branch, branch with ack), a hand-written long-latency discard sequence,
// and a randomized run against a transaction-level reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        Branch_taken;
    logic [31:0] Branch_Address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC_out;
    logic [31:0] Instruction_out;
    logic        valid_out;
    logic        fetch_stall;
    logic [31:0] stall_cycles;
    logic [15:0] discard_count;

    if_fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .Branch_taken   (Branch_taken),
        .Branch_Address (Branch_Address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .PC_out         (PC_out),
        .Instruction_out(Instruction_out),
        .valid_out      (valid_out),
        .fetch_stall    (fetch_stall),
        .stall_cycles   (stall_cycles),
        .discard_count  (discard_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    int unsigned mem_lat   = 0;
    bit          mem_rand  = 1'b0;
    int unsigned data_mode = 0;
    bit          mem_pending = 1'b0;
    int unsigned mem_cnt = 0;
    logic [31:0] mem_a = 32'h0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (data_mode)
            0:       return a >> 2;
            1:       return 32'hAAAA_0001;
            default: return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    // Called at the negedge: decides ack/rdata for the coming posedge.
    task automatic mem_step();
        int unsigned lat;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (!rst) begin
            mem_pending = 1'b0;
        end else if (mem_pending) begin
            if (imem_req) chk("addr_stable", imem_addr, mem_a);
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_ack    = 1'b1;
                imem_rdata  = mem_data(mem_a);
                mem_pending = 1'b0;
            end
        end else if (imem_req) begin
            lat   = mem_rand ? $urandom_range(0, 3) : mem_lat;
            mem_a = imem_addr;
            if (lat == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_data(mem_a);
            end else begin
                mem_pending = 1'b1;
                mem_cnt     = lat;
            end
        end
    endtask

    task automatic drive(input logic frz, input logic br, input logic [31:0] tgt);
        freeze         = frz;
        Branch_taken   = br;
        Branch_Address = tgt;
        mem_step();
    endtask

    task automatic adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b0;
        freeze         = 1'b0;
        Branch_taken   = 1'b0;
        Branch_Address = 32'h0;
        imem_ack       = 1'b0;
        mem_pending    = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    logic        m_doomed;
    logic [31:0] m_stall;
    logic [15:0] m_disc;

    task automatic model_edge(input logic frz, input logic br, input logic [31:0] tgt,
                              input logic ack, input logic [31:0] rd);
        if (!m_valid) m_stall = m_stall + 32'd1;
        if (m_valid) begin
            if (br) begin
                m_valid = 1'b0;
                m_pc    = tgt;
            end else if (!frz) begin
                m_valid = 1'b0;
                m_pc    = m_pc + 32'd4;
            end
        end else if (m_doomed) begin
            if (br) m_pc = tgt;
            if (ack) begin
                m_doomed = 1'b0;
                m_disc   = m_disc + 16'd1;
            end
        end else if (br) begin
            m_pc = tgt;
            if (ack) m_disc = m_disc + 16'd1;
            else     m_doomed = 1'b1;
        end else if (ack) begin
            m_valid = 1'b1;
            m_inst  = rd;
            m_ipc   = m_pc;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        frz;
        logic        br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic frz, input logic br, input logic [31:0] tgt,
                                input logic req, input logic [31:0] addr, input logic valid,
                                input logic [31:0] inst, input logic [31:0] pc);
        vec_t v;
        v.frz = frz; v.br = br; v.tgt = tgt; v.req = req; v.addr = addr;
        v.valid = valid; v.inst = inst; v.pc = pc;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        found;
        logic        frz;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] a;

        // Zero-wait table: 8 sequential fetches, 5-cycle freeze, freeze+branch, branch with ack.
        for (int k = 0; k < 8; k++) begin
            a = RST_PC + 32'(4 * k);
            tbl[2*k]     = mk(1'b0, 1'b0, 32'h0, 1'b1, a, 1'b0, 32'h0, 32'h0);
            tbl[2*k + 1] = mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, a >> 2, a + 32'd4);
        end
        tbl[16] = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h120, 1'b0, 32'h0, 32'h0);
        for (int k = 17; k <= 21; k++)
            tbl[k] = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h48, 32'h124);
        tbl[22] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h48,  32'h124);
        tbl[23] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h124, 1'b0, 32'h0,   32'h0);
        tbl[24] = mk(1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   1'b1, 32'h49,  32'h128);
        tbl[25] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   32'h0);
        tbl[26] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  32'h204);
        tbl[27] = mk(1'b0, 1'b1, 32'h800, 1'b1, 32'h204, 1'b0, 32'h0,   32'h0);
        tbl[28] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h800, 1'b0, 32'h0,   32'h0);
        tbl[29] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200, 32'h804);

        // ---- reset behaviour, memory acks one cycle after request ----
        freeze = 1'b0; Branch_taken = 1'b0; Branch_Address = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        rst = 1'b1;
        #1 rst = 1'b0;
        data_mode = 1; mem_lat = 1; mem_rand = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_req",   32'(imem_req),    32'd0);
            chk("rst_valid", 32'(valid_out),   32'd0);
            chk("rst_stall", 32'(fetch_stall), 32'd1);
            chk("rst_inst",  Instruction_out,  32'h0);
            chk("rst_pcout", PC_out,           32'h4);
        end
        rst = 1'b1;
        #1;
        drive(1'b0, 1'b0, 32'h0);
        chk("rel_req",  32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr,     RST_PC);
        adv();
        drive(1'b0, 1'b0, 32'h0);
        chk("rel_ackcyc_valid", 32'(valid_out), 32'd0);
        adv();
        drive(1'b0, 1'b0, 32'h0);
        chk("rel_valid", 32'(valid_out), 32'd1);
        chk("rel_inst",  Instruction_out, 32'hAAAA_0001);
        chk("rel_pcout", PC_out,          32'h104);
        adv();

        // ---- table-driven zero-wait vectors ----
        do_reset(2);
        data_mode = 0; mem_lat = 0;
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].frz, tbl[i].br, tbl[i].tgt);
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(valid_out), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_stall", i), 32'(fetch_stall), 32'(!tbl[i].valid));
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d_inst", i), Instruction_out, tbl[i].inst);
                chk($sformatf("tbl%0d_pcout", i), PC_out, tbl[i].pc);
            end
            adv();
        end
        drive(1'b0, 1'b0, 32'h0);
        chk("tbl_discard", 32'(discard_count), PERF ? 32'd1 : 32'd0);

        // ---- 3-cycle latency memory, redirect while request outstanding ----
        do_reset(2);
        data_mode = 0; mem_lat = 3;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            drive(1'b0, 1'b0, 32'h0);
            if (imem_req && imem_addr == 32'h108) begin
                found = 1'b1;
                break;
            end
            adv();
        end
        chk("lat_reach_108", 32'(found), 32'd1);
        adv();
        drive(1'b0, 1'b1, 32'h400);
        chk("lat_br_req",  32'(imem_req), 32'd1);
        chk("lat_br_addr", imem_addr,     32'h108);
        adv();
        drive(1'b0, 1'b0, 32'h0);
        chk("lat_disc1_req",   32'(imem_req),  32'd0);
        chk("lat_disc1_valid", 32'(valid_out), 32'd0);
        adv();
        drive(1'b0, 1'b0, 32'h0);
        chk("lat_disc2_req",   32'(imem_req),  32'd0);
        chk("lat_disc2_valid", 32'(valid_out), 32'd0);
        adv();
        drive(1'b0, 1'b0, 32'h0);
        chk("lat_refetch_req",   32'(imem_req),  32'd1);
        chk("lat_refetch_addr",  imem_addr,      32'h400);
        chk("lat_refetch_valid", 32'(valid_out), 32'd0);
        for (int c = 0; c < 10; c++) begin
            adv();
            drive(1'b0, 1'b0, 32'h0);
            if (valid_out) break;
        end
        chk("lat_valid",   32'(valid_out),     32'd1);
        chk("lat_inst",    Instruction_out,    32'h100);
        chk("lat_pcout",   PC_out,             32'h404);
        chk("lat_discard", 32'(discard_count), PERF ? 32'd1 : 32'd0);
        adv();

        // ---- randomized run against the reference model ----
        do_reset(2);
        data_mode = 2; mem_rand = 1'b1;
        m_pc = RST_PC; m_valid = 1'b0; m_inst = 32'h0; m_ipc = 32'h0;
        m_doomed = 1'b0; m_stall = 32'h0; m_disc = 16'h0;
        for (int c = 0; c < 600; c++) begin
            frz = ($urandom_range(0, 99) < 30);
            br  = ($urandom_range(0, 99) < 12);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFFC;
                1:       tgt = 32'hFFFF_FFF8;
                default: tgt = $urandom & 32'hFFFF_FFFC;
            endcase
            drive(frz, br, tgt);
            chk("rnd_req",   32'(imem_req),    32'(!m_valid && !m_doomed));
            if (!m_valid && !m_doomed) chk("rnd_addr", imem_addr, m_pc);
            chk("rnd_valid", 32'(valid_out),   32'(m_valid));
            chk("rnd_stall", 32'(fetch_stall), 32'(!m_valid));
            if (m_valid) begin
                chk("rnd_inst",  Instruction_out, m_inst);
                chk("rnd_pcout", PC_out,          m_ipc + 32'd4);
                chk("rnd_mem",   Instruction_out, mem_data(PC_out - 32'd4));
            end
            chk("rnd_stall_cnt", stall_cycles,        PERF ? m_stall : 32'd0);
            chk("rnd_disc_cnt",  32'(discard_count),  PERF ? 32'(m_disc) : 32'd0);
            model_edge(frz, br, tgt, imem_ack, imem_rdata);
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
